// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned FIELD_W = 6;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched word and its PC while decode stalls.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               unload_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] data_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               full_o
);

  logic [INSTR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               full_q, full_d;

  // clear wins over load so a redirect never leaves stale data behind
  always_comb begin
    data_d = data_q;
    pc_d   = pc_q;
    full_d = full_q;
    if (clear_i) begin
      data_d = NOP_INSTR;
      full_d = 1'b0;
    end else if (load_i) begin
      data_d = data_i;
      pc_d   = pc_i;
      full_d = 1'b1;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= NOP_INSTR;
      pc_q   <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pc_q   <= pc_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign pc_o   = pc_q;
  assign full_o = full_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack handshake, stall skid and redirect flush.
// Optional perf counters (perf_fetched, perf_bubbles) enabled by FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic [FIELD_W-1:0] op,
  output logic [FIELD_W-1:0] funct,
  output logic               instr_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic               req_q;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]  pc_plus4_q;
  logic               instr_valid_q, instr_valid_d;

  logic               skid_load, skid_unload, skid_clear, skid_full;
  logic [INSTR_W-1:0] skid_data;
  logic [ADDR_W-1:0]  skid_pc;

  logic               slot_free_c;
  logic               redirect_act_c;
  logic [ADDR_W-1:0]  redirect_tgt_c;
  logic [ADDR_W-1:0]  pc_next_c;

  assign slot_free_c    = !instr_valid_q || !stall;
  assign redirect_act_c = redirect && (state_q != ST_IDLE);
  assign redirect_tgt_c = redirect_pc & ~ADDR_W'(3);
  assign pc_next_c      = pc_q + ADDR_W'(PC_STEP);

  fetch_skid #(.ADDR_W(ADDR_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .data_i   (imem_rdata),
    .pc_i     (req_addr_q),
    .data_o   (skid_data),
    .pc_o     (skid_pc),
    .full_o   (skid_full)
  );

  // Next-state and datapath; a redirect outranks ack and stall in every active state
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_clear    = 1'b0;

    if (redirect_act_c) begin
      instr_d       = NOP_INSTR;
      instr_valid_d = 1'b0;
      skid_clear    = 1'b1;
      pc_d          = redirect_tgt_c;
    end

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_FETCH;
        req_addr_d = pc_q;
      end
      ST_FETCH: begin
        if (redirect_act_c) begin
          if (imem_ack) begin
            req_addr_d = redirect_tgt_c;
          end else begin
            state_d = ST_FLUSH;
          end
        end else if (imem_ack) begin
          pc_d = pc_next_c;
          if (slot_free_c) begin
            instr_d       = imem_rdata;
            instr_pc_d    = req_addr_q;
            instr_valid_d = 1'b1;
            req_addr_d    = pc_next_c;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end else if (slot_free_c) begin
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (redirect_act_c) begin
          state_d    = ST_FETCH;
          req_addr_d = redirect_tgt_c;
        end else if (!stall && skid_full) begin
          instr_d       = skid_data;
          instr_pc_d    = skid_pc;
          instr_valid_d = 1'b1;
          skid_unload   = 1'b1;
          state_d       = ST_FETCH;
          req_addr_d    = pc_q;
        end
      end
      ST_FLUSH: begin
        // stale request must still complete before the target is fetched
        if (!redirect_act_c && imem_ack) begin
          state_d    = ST_FETCH;
          req_addr_d = pc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      req_q         <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      pc_plus4_q    <= ADDR_W'(PC_STEP);
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      req_q         <= (state_d == ST_FETCH) || (state_d == ST_FLUSH);
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      pc_plus4_q    <= instr_pc_d + ADDR_W'(PC_STEP);
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q;

  // An instruction enters the slot whenever it becomes valid while the slot was free
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      if (instr_valid_d && slot_free_c) perf_fetched_q <= perf_fetched_q + 32'd1;
      if ((state_q != ST_IDLE) && !instr_valid_q) perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = req_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = pc_plus4_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a latency-programmable memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4),
    .op          (op),
    .funct       (funct),
    .instr_valid (instr_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  // Memory returns the address as data; acks once the request has waited mem_lat cycles
  int mem_lat  = 0;
  int wait_cnt = 0;
  assign imem_ack   = imem_req && (wait_cnt >= mem_lat);
  assign imem_rdata = imem_addr;

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_ipc;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs[NV];

  function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] rpc, int lat,
                              logic eq, logic [31:0] ea, logic ev, logic [31:0] eipc);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = d; v.rpc = rpc; v.lat = lat;
    v.e_req = eq; v.e_addr = ea; v.e_v = ev; v.e_ipc = eipc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ei;
    bit          seen;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //            rst stl red rpc           lat  req addr          v  ipc
    vecs[0]  = mk(1, 0, 0, 32'h0,          0,   0, 32'h0,         0, 32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h0,          0,   0, 32'h0,         0, 32'h0);
    vecs[2]  = mk(0, 0, 0, 32'h0,          0,   1, 32'h0,         0, 32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,          0,   1, 32'h4,         1, 32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,          0,   1, 32'h8,         1, 32'h4);
    vecs[5]  = mk(0, 0, 0, 32'h0,          0,   1, 32'hC,         1, 32'h8);
    vecs[6]  = mk(0, 1, 0, 32'h0,          0,   0, 32'hC,         1, 32'h8);
    vecs[7]  = mk(0, 1, 0, 32'h0,          0,   0, 32'hC,         1, 32'h8);
    vecs[8]  = mk(0, 1, 0, 32'h0,          0,   0, 32'hC,         1, 32'h8);
    vecs[9]  = mk(0, 0, 0, 32'h0,          0,   1, 32'h10,        1, 32'hC);
    vecs[10] = mk(0, 0, 0, 32'h0,          0,   1, 32'h14,        1, 32'h10);
    vecs[11] = mk(0, 0, 0, 32'h0,          2,   1, 32'h14,        0, 32'h0);
    vecs[12] = mk(0, 0, 1, 32'h100,        2,   1, 32'h14,        0, 32'h0);
    vecs[13] = mk(0, 0, 0, 32'h0,          2,   1, 32'h100,       0, 32'h0);
    vecs[14] = mk(0, 0, 0, 32'h0,          2,   1, 32'h100,       0, 32'h0);
    vecs[15] = mk(0, 0, 0, 32'h0,          2,   1, 32'h100,       0, 32'h0);
    vecs[16] = mk(0, 0, 0, 32'h0,          2,   1, 32'h104,       1, 32'h100);
    vecs[17] = mk(0, 0, 0, 32'h0,          0,   1, 32'h108,       1, 32'h104);
    vecs[18] = mk(0, 0, 1, 32'h203,        0,   1, 32'h200,       0, 32'h0);
    vecs[19] = mk(0, 0, 0, 32'h0,          0,   1, 32'h204,       1, 32'h200);
    vecs[20] = mk(0, 1, 0, 32'h0,          0,   0, 32'h204,       1, 32'h200);
    vecs[21] = mk(0, 1, 1, 32'h300,        0,   1, 32'h300,       0, 32'h0);
    vecs[22] = mk(0, 1, 0, 32'h0,          0,   1, 32'h304,       1, 32'h300);
    vecs[23] = mk(0, 1, 0, 32'h0,          0,   0, 32'h304,       1, 32'h300);
    vecs[24] = mk(0, 0, 0, 32'h0,          0,   1, 32'h308,       1, 32'h304);
    vecs[25] = mk(0, 0, 1, 32'hFFFF_FFF8,  0,   1, 32'hFFFF_FFF8, 0, 32'h0);
    vecs[26] = mk(0, 0, 0, 32'h0,          0,   1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8);
    vecs[27] = mk(0, 0, 0, 32'h0,          0,   1, 32'h0,         1, 32'hFFFF_FFFC);
    vecs[28] = mk(0, 0, 0, 32'h0,          0,   1, 32'h4,         1, 32'h0);
    vecs[29] = mk(0, 0, 0, 32'h0,          2,   1, 32'h4,         0, 32'h0);
    vecs[30] = mk(0, 0, 1, 32'h400,        2,   1, 32'h4,         0, 32'h0);
    vecs[31] = mk(1, 0, 0, 32'h0,          2,   0, 32'h0,         0, 32'h0);
    vecs[32] = mk(0, 0, 1, 32'h500,        0,   1, 32'h0,         0, 32'h0);
    vecs[33] = mk(0, 0, 0, 32'h0,          0,   1, 32'h4,         1, 32'h0);

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; stall = vecs[i].stall; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc; mem_lat = vecs[i].lat;
      step();
      ei = vecs[i].e_v ? vecs[i].e_ipc : 32'h0;
      chk($sformatf("r%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      chk($sformatf("r%0d_valid", i), 32'(instr_valid), 32'(vecs[i].e_v));
      chk($sformatf("r%0d_instr", i), instr, ei);
      if (vecs[i].e_req) chk($sformatf("r%0d_addr", i), imem_addr, vecs[i].e_addr);
      if (vecs[i].e_v) begin
        chk($sformatf("r%0d_ipc", i), instr_pc, vecs[i].e_ipc);
        chk($sformatf("r%0d_pc4", i), pc_plus4, vecs[i].e_ipc + 32'd4);
        chk($sformatf("r%0d_op", i), 32'(op), 32'(ei[31:26]));
        chk($sformatf("r%0d_funct", i), 32'(funct), 32'(ei[5:0]));
      end
    end

    // Back-to-back redirects while a slow stale request is pending
    redirect = 1'b0; stall = 1'b0; mem_lat = 3;
    step();
    chk("flush_pre_valid", 32'(instr_valid), 32'h0);
    redirect = 1'b1; redirect_pc = 32'h600;
    step();
    chk("flush_enter_req", 32'(imem_req), 32'h1);
    chk("flush_enter_addr", imem_addr, 32'h4);
    redirect_pc = 32'h700;
    step();
    chk("flush_over_addr", imem_addr, 32'h4);
    chk("flush_over_valid", 32'(instr_valid), 32'h0);
    redirect = 1'b0;
    step();
    chk("flush_exit_addr", imem_addr, 32'h700);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (instr_valid) seen = 1'b1;
    end
    chk("flush_target_seen", 32'(seen), 32'h1);
    chk("flush_target_ipc", instr_pc, 32'h700);
    chk("flush_target_instr", instr, 32'h700);

    // Reset from a running state, then restart from RESET_PC
    mem_lat = 0; rst = 1'b1;
    step();
    chk("rst2_req", 32'(imem_req), 32'h0);
    chk("rst2_valid", 32'(instr_valid), 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst2_perf_fetched", perf_fetched, 32'h0);
    chk("rst2_perf_bubbles", perf_bubbles, 32'h0);
`endif
    rst = 1'b0;
    step();
    chk("rst2_first_addr", imem_addr, 32'h0);
    step();
    step();
    chk("rst2_ipc", instr_pc, 32'h4);
    chk("rst2_v", 32'(instr_valid), 32'h1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd2);
    chk("perf_bubbles", perf_bubbles, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
